// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state encoding and default geometry for the SRAM read checker.
package sram_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH
    } chk_state_t;

endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: RD_LAT-deep valid/address delay line. It tags every SRAM read
// request so the returning data can be matched to the address it came from.
module sram_rd_pipe #(
    parameter int ADDR_WIDTH = 5,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr
);

    logic [RD_LAT-1:0]            valid_sr;
    logic [RD_LAT*ADDR_WIDTH-1:0] addr_sr;

    generate
        if (RD_LAT == 1) begin : g_single
            // Single stage: capture the request tag for one cycle; reset drops in-flight reads
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_sr <= '0;
                    addr_sr  <= '0;
                end else begin
                    valid_sr <= in_valid;
                    addr_sr  <= in_addr;
                end
            end
        end else begin : g_multi
            // Multi stage: shift tags toward the MSB end; reset drops in-flight reads
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_sr <= '0;
                    addr_sr  <= '0;
                end else begin
                    valid_sr <= {valid_sr[RD_LAT-2:0], in_valid};
                    addr_sr  <= {addr_sr[(RD_LAT-1)*ADDR_WIDTH-1:0], in_addr};
                end
            end
        end
    endgenerate

    assign out_valid = valid_sr[RD_LAT-1];
    assign out_addr  = addr_sr[RD_LAT*ADDR_WIDTH-1 -: ADDR_WIDTH];

endmodule

// File: rtl/sram_read_checker.sv
// sram_read_checker: sweeps every SRAM address once per start, compares the
// returned words against an expected pattern and reports mismatch statistics.
// Optional macro SRAM_CHK_CKBD_EN: expected data alternates exp_data (even
// addresses) and ~exp_data (odd addresses) instead of exp_data everywhere.
module sram_read_checker #(
    parameter int WIDTH  = sram_pkg::DEFAULT_WIDTH,
    parameter int DEPTH  = sram_pkg::DEFAULT_DEPTH,
    parameter int RD_LAT = 1,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int ERR_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      exp_data,
    output logic                  re_req,
    output logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [WIDTH-1:0]      dout_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    import sram_pkg::*;

    chk_state_t            state;
    chk_state_t            state_next;
    logic [WIDTH-1:0]      exp_q;
    logic                  pass_q;
    logic [2:0]            drain_cnt;
    logic                  start_accept;
    logic                  last_issue;
    logic                  tag_valid;
    logic [ADDR_WIDTH-1:0] tag_addr;
    logic [WIDTH-1:0]      expected_word;
    logic                  mismatch;

    assign start_accept = (state == IDLE) && start;
    assign last_issue   = re_req && (addr_out == ADDR_WIDTH'(DEPTH - 1));

    // State register; reset aborts any sweep without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the busy/done status that follows directly from the state
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                busy = 1'b1;
                if (last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == 3'(RD_LAT - 1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counts cycles spent in DRAIN so the last read has time to return
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + 3'd1;
        end else begin
            drain_cnt <= '0;
        end
    end

    // Request generator: first READ cycle arms address 0, then one address per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            re_req   <= 1'b0;
            addr_out <= '0;
            exp_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q  <= exp_data;
                        pass_q <= 1'b0;
                    end
                end
                READ: begin
                    if (!re_req) begin
                        re_req   <= 1'b1;
                        addr_out <= '0;
                    end else if (last_issue) begin
                        re_req <= 1'b0;
                    end else begin
                        addr_out <= addr_out + 1'b1;
                    end
                end
                FINISH: begin
                    pass_q <= (err_count == '0);
                end
                default: begin
                end
            endcase
        end
    end

    sram_rd_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RD_LAT     (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (re_req),
        .in_addr   (addr_out),
        .out_valid (tag_valid),
        .out_addr  (tag_addr)
    );

`ifdef SRAM_CHK_CKBD_EN
    assign expected_word = tag_addr[0] ? ~exp_q : exp_q;
`else
    assign expected_word = exp_q;
`endif

    assign mismatch = tag_valid && (dout_in != expected_word);

    // Mismatch bookkeeping: saturating error count and address of the first failure
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (start_accept) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (mismatch) begin
            if (err_count != ERR_WIDTH'(DEPTH)) begin
                err_count <= err_count + 1'b1;
            end
            if (err_count == '0) begin
                first_err_addr <= tag_addr;
            end
        end
    end

    // During FINISH the final count is already settled, so pass is shown with done
    assign pass = (state == FINISH) ? (err_count == '0) : pass_q;

endmodule

// File: tb/tb_sram_read_checker.sv
// tb_sram_read_checker: drives full read sweeps against a behavioural SRAM and
// compares the checker's verdicts with a reference computed from the memory image.
module tb_sram_read_checker;

    localparam int WIDTH      = 4;
    localparam int DEPTH      = 32;
    localparam int RD_LAT     = 1;
    localparam int AW         = 5;
    localparam int EW         = 6;
    localparam int SWEEP_TIME = DEPTH + RD_LAT + 1;
    localparam int LIMIT      = 200;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] exp_data;
    logic             re_req;
    logic [AW-1:0]    addr_out;
    logic [WIDTH-1:0] dout_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [EW-1:0]    err_count;
    logic [AW-1:0]    first_err_addr;

    logic [WIDTH-1:0] mem [DEPTH];

    int n_checks;
    int n_fail;

    int            obs_done_cnt;
    int            obs_done_cyc;
    int            obs_rd_cnt;
    bit            obs_seq_ok;
    bit            obs_busy_after;
    logic [EW-1:0] obs_err;
    logic [AW-1:0] obs_first;
    logic          obs_pass;
    logic          obs_pass_held;

    sram_read_checker dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .exp_data       (exp_data),
        .re_req         (re_req),
        .addr_out       (addr_out),
        .dout_in        (dout_in),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM with a one-cycle read latency
    always @(posedge clk) begin
        if (re_req) dout_in <= mem[addr_out];
    end

    function automatic logic [WIDTH-1:0] ref_word(input int a, input logic [WIDTH-1:0] p);
`ifdef SRAM_CHK_CKBD_EN
        return (a % 2 == 1) ? ~p : p;
`else
        return p;
`endif
    endfunction

    task automatic fill_uniform(input logic [WIDTH-1:0] v);
        for (int a = 0; a < DEPTH; a++) mem[a] = v;
    endtask

    task automatic fill_matching(input logic [WIDTH-1:0] p);
        for (int a = 0; a < DEPTH; a++) mem[a] = ref_word(a, p);
    endtask

    task automatic model_sweep(input logic [WIDTH-1:0] p, output int errs, output int first);
        errs  = 0;
        first = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (mem[a] != ref_word(a, p)) begin
                if (errs == 0) first = a;
                errs++;
            end
        end
    endtask

    // mode 0: plain sweep, 1: extra start mid-sweep, 2: start coincident with done
    task automatic applyStimulus(input logic [WIDTH-1:0] pattern, input int mode);
        int c;
        obs_done_cnt = 0; obs_done_cyc = -1; obs_rd_cnt = 0;
        obs_seq_ok = 1'b1; obs_busy_after = 1'b0;
        obs_err = '0; obs_first = '0; obs_pass = 1'bx; obs_pass_held = 1'bx;
        @(negedge clk); exp_data = pattern; start = 1'b1;
        @(negedge clk); start = 1'b0; exp_data = ~pattern;
        c = 0;
        while (c < LIMIT) begin
            if (re_req === 1'b1) begin
                if (int'(addr_out) != obs_rd_cnt) obs_seq_ok = 1'b0;
                obs_rd_cnt++;
            end
            if (done === 1'b1) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc = c; obs_err = err_count; obs_first = first_err_addr; obs_pass = pass;
                end
            end
            if (obs_done_cyc >= 0 && c > obs_done_cyc && busy !== 1'b0) obs_busy_after = 1'b1;
            if (obs_done_cyc >= 0 && c == obs_done_cyc + 2) obs_pass_held = pass;
            start = 1'b0;
            if (mode == 1 && c == 5) start = 1'b1;
            if (mode == 2 && done === 1'b1) start = 1'b1;
            if (obs_done_cyc >= 0 && c >= obs_done_cyc + 4) break;
            @(negedge clk); c++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (re_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset re_req: got %b want 0", re_req); end
        n_checks++; if (addr_out !== '0) begin n_fail++; $display("[TB] FAIL reset addr_out: got %0d want 0", addr_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset done: got %b want 0", done); end
        n_checks++; if (pass !== 1'b0) begin n_fail++; $display("[TB] FAIL reset pass: got %b want 0", pass); end
        n_checks++; if (err_count !== '0) begin n_fail++; $display("[TB] FAIL reset err_count: got %0d want 0", err_count); end
        n_checks++; if (first_err_addr !== '0) begin n_fail++; $display("[TB] FAIL reset first_err_addr: got %0d want 0", first_err_addr); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_sweep();
        int re, rf;
        fill_matching(4'b1010);
        model_sweep(4'b1010, re, rf);
        applyStimulus(4'b1010, 0);
        n_checks++; if (obs_done_cyc != SWEEP_TIME) begin n_fail++; $display("[TB] FAIL clean sweep_time: got %0d want %0d", obs_done_cyc, SWEEP_TIME); end
        n_checks++; if (obs_rd_cnt != DEPTH) begin n_fail++; $display("[TB] FAIL clean re_req_cycles: got %0d want %0d", obs_rd_cnt, DEPTH); end
        n_checks++; if (obs_seq_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL clean addr_sequence: got broken want 0..%0d", DEPTH - 1); end
        n_checks++; if (obs_done_cnt != 1) begin n_fail++; $display("[TB] FAIL clean done_pulses: got %0d want 1", obs_done_cnt); end
        n_checks++; if (obs_err !== EW'(re)) begin n_fail++; $display("[TB] FAIL clean err_count: got %0d want %0d", obs_err, re); end
        n_checks++; if (obs_pass !== 1'b1) begin n_fail++; $display("[TB] FAIL clean pass: got %b want 1", obs_pass); end
        n_checks++; if (obs_pass_held !== 1'b1) begin n_fail++; $display("[TB] FAIL clean pass_held: got %b want 1", obs_pass_held); end
        n_checks++; if (obs_busy_after !== 1'b0) begin n_fail++; $display("[TB] FAIL clean busy_after_done: got 1 want 0"); end
    endtask

    task automatic test_single_error();
        fill_matching(4'b1010);
        mem[7] = 4'b0000;
        applyStimulus(4'b1010, 0);
        n_checks++; if (obs_err !== EW'(1)) begin n_fail++; $display("[TB] FAIL single err_count: got %0d want 1", obs_err); end
        n_checks++; if (obs_first !== AW'(7)) begin n_fail++; $display("[TB] FAIL single first_err_addr: got %0d want 7", obs_first); end
        n_checks++; if (obs_pass !== 1'b0) begin n_fail++; $display("[TB] FAIL single pass: got %b want 0", obs_pass); end
        n_checks++; if (obs_pass_held !== 1'b0) begin n_fail++; $display("[TB] FAIL single pass_held: got %b want 0", obs_pass_held); end
    endtask

    task automatic test_two_errors();
        fill_matching(4'b1010);
        mem[3]  = 4'b0000;
        mem[20] = 4'b0000;
        applyStimulus(4'b1010, 0);
        n_checks++; if (obs_err !== EW'(2)) begin n_fail++; $display("[TB] FAIL two err_count: got %0d want 2", obs_err); end
        n_checks++; if (obs_first !== AW'(3)) begin n_fail++; $display("[TB] FAIL two first_err_addr: got %0d want 3", obs_first); end
        n_checks++; if (obs_done_cyc != SWEEP_TIME) begin n_fail++; $display("[TB] FAIL two sweep_time: got %0d want %0d", obs_done_cyc, SWEEP_TIME); end
    endtask

    task automatic test_all_errors();
        int re, rf;
        fill_matching(4'b0110);
        for (int a = 0; a < DEPTH; a++) mem[a] = ~mem[a];
        model_sweep(4'b0110, re, rf);
        applyStimulus(4'b0110, 0);
        n_checks++; if (obs_err !== EW'(re)) begin n_fail++; $display("[TB] FAIL all err_count: got %0d want %0d", obs_err, re); end
        n_checks++; if (obs_first !== AW'(rf)) begin n_fail++; $display("[TB] FAIL all first_err_addr: got %0d want %0d", obs_first, rf); end
    endtask

    task automatic test_start_during_busy();
        fill_matching(4'b1100);
        applyStimulus(4'b1100, 1);
        n_checks++; if (obs_done_cnt != 1) begin n_fail++; $display("[TB] FAIL busy_start done_pulses: got %0d want 1", obs_done_cnt); end
        n_checks++; if (obs_seq_ok !== 1'b1 || obs_rd_cnt != DEPTH) begin n_fail++; $display("[TB] FAIL busy_start addr_sequence: got %0d reads ok=%b want %0d ok=1", obs_rd_cnt, obs_seq_ok, DEPTH); end
        n_checks++; if (obs_done_cyc != SWEEP_TIME) begin n_fail++; $display("[TB] FAIL busy_start sweep_time: got %0d want %0d", obs_done_cyc, SWEEP_TIME); end
    endtask

    task automatic test_start_with_done();
        fill_matching(4'b0011);
        applyStimulus(4'b0011, 2);
        n_checks++; if (obs_busy_after !== 1'b0) begin n_fail++; $display("[TB] FAIL done_start busy_after_done: got 1 want 0"); end
        n_checks++; if (obs_pass_held !== 1'b1) begin n_fail++; $display("[TB] FAIL done_start pass_held: got %b want 1", obs_pass_held); end
    endtask

    task automatic test_reset_mid_sweep();
        int  c;
        bit  saw_done;
        int  max_err;
        fill_matching(4'b1010);
        mem[10] = ~mem[10];
        @(negedge clk); exp_data = 4'b1010; start = 1'b1;
        @(negedge clk); start = 1'b0;
        c = 0;
        while (!(re_req === 1'b1 && addr_out === AW'(10)) && c < LIMIT) begin
            @(negedge clk); c++;
        end
        n_checks++; if (c >= LIMIT) begin n_fail++; $display("[TB] FAIL midrst reach_addr10: got timeout want addr 10 issued"); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (re_req !== 1'b0 || addr_out !== '0) begin n_fail++; $display("[TB] FAIL midrst request: got re_req=%b addr=%0d want 0/0", re_req, addr_out); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst status: got busy=%b done=%b pass=%b want 0/0/0", busy, done, pass); end
        n_checks++; if (err_count !== '0 || first_err_addr !== '0) begin n_fail++; $display("[TB] FAIL midrst stats: got err=%0d first=%0d want 0/0", err_count, first_err_addr); end
        rst = 1'b0;
        saw_done = 1'b0;
        max_err = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
            if (int'(err_count) > max_err) max_err = int'(err_count);
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst no_done: got done pulse want none"); end
        n_checks++; if (max_err != 0) begin n_fail++; $display("[TB] FAIL midrst inflight_discard: got err=%0d want 0", max_err); end
        mem[10] = ~mem[10];
        applyStimulus(4'b1010, 0);
        n_checks++; if (obs_done_cyc != SWEEP_TIME) begin n_fail++; $display("[TB] FAIL midrst fresh_sweep_time: got %0d want %0d", obs_done_cyc, SWEEP_TIME); end
        n_checks++; if (obs_pass !== 1'b1 || obs_err !== '0) begin n_fail++; $display("[TB] FAIL midrst fresh_result: got pass=%b err=%0d want 1/0", obs_pass, obs_err); end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] p;
        int               nerr;
        int               re, rf;
        for (int it = 0; it < 5; it++) begin
            p = WIDTH'($urandom_range(0, 15));
            fill_matching(p);
            nerr = $urandom_range(0, 6);
            for (int k = 0; k < nerr; k++) begin
                int a;
                a = $urandom_range(0, DEPTH - 1);
                mem[a] = mem[a] ^ WIDTH'($urandom_range(1, 15));
            end
            model_sweep(p, re, rf);
            applyStimulus(p, 0);
            n_checks++; if (obs_err !== EW'(re)) begin n_fail++; $display("[TB] FAIL random%0d err_count: got %0d want %0d", it, obs_err, re); end
            n_checks++; if (obs_first !== AW'(rf)) begin n_fail++; $display("[TB] FAIL random%0d first_err_addr: got %0d want %0d", it, obs_first, rf); end
            n_checks++; if (obs_pass !== (re == 0)) begin n_fail++; $display("[TB] FAIL random%0d pass: got %b want %b", it, obs_pass, (re == 0)); end
        end
    endtask

`ifdef SRAM_CHK_CKBD_EN
    task automatic test_checkerboard();
        fill_matching(4'b1010);
        applyStimulus(4'b1010, 0);
        n_checks++; if (obs_pass !== 1'b1) begin n_fail++; $display("[TB] FAIL ckbd_alt pass: got %b want 1", obs_pass); end
        fill_uniform(4'b1010);
        applyStimulus(4'b1010, 0);
        n_checks++; if (obs_err !== EW'(16)) begin n_fail++; $display("[TB] FAIL ckbd_uniform err_count: got %0d want 16", obs_err); end
        n_checks++; if (obs_first !== AW'(1)) begin n_fail++; $display("[TB] FAIL ckbd_uniform first_err_addr: got %0d want 1", obs_first); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        exp_data = '0;
        fill_uniform('0);
        test_reset();
        test_clean_sweep();
        test_single_error();
        test_two_errors();
        test_all_errors();
        test_start_during_busy();
        test_start_with_done();
        test_reset_mid_sweep();
        test_random();
`ifdef SRAM_CHK_CKBD_EN
        test_checkerboard();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_read_checker.md
SRAM_READ_CHECKER -- requirements
Module: sram_read_checker

Interface
REQ-001 Parameter WIDTH, default 4, data width of the SRAM word.
REQ-002 Parameter DEPTH, default 32, number of SRAM words; ADDR_WIDTH = $clog2(DEPTH).
REQ-003 Parameter RD_LAT, default 1, cycles from re_req sampled high to dout valid (range 1..4).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a full read sweep when idle.
REQ-007 exp_data  input  WIDTH  expected pattern; sampled on accepted start.
REQ-008 re_req  output  1  read request to SRAM, registered.
REQ-009 addr_out  output  ADDR_WIDTH  SRAM read address, registered.
REQ-010 dout_in  input  WIDTH  SRAM read data.
REQ-011 busy  output  1  high from accepted start until done pulse.
REQ-012 done  output  1  one-cycle pulse at end of sweep.
REQ-013 pass  output  1  high when the last sweep had zero mismatches; held until next accepted start.
REQ-014 err_count  output  $clog2(DEPTH+1)  mismatch count of the current/last sweep.
REQ-015 first_err_addr  output  ADDR_WIDTH  address of the first mismatch; 0 if none.

Function
REQ-016 FSM states SHALL be IDLE, READ, DRAIN, FINISH.
REQ-017 IDLE: start=1 -> READ; exp_data latched; err_count, first_err_addr, pass cleared; busy=1 next cycle.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 READ: re_req=1 every cycle, addr_out 0,1,...,DEPTH-1 consecutively, one address per cycle.
REQ-020 After addr DEPTH-1 is issued, the FSM SHALL go to DRAIN with re_req=0 and addr_out held.
REQ-021 DRAIN SHALL last exactly RD_LAT cycles, then go to FINISH.
REQ-022 A RD_LAT-deep valid/address shift pipeline SHALL tag each request; dout_in is compared when the tagged valid emerges.
REQ-023 Mismatch (dout_in != expected for that address): err_count increments by 1; on first mismatch of the sweep, first_err_addr takes the tagged address.
REQ-024 err_count SHALL not wrap (max DEPTH fits its width).
REQ-025 FINISH: done=1 for one cycle, busy=0, pass=(err_count==0); next state IDLE.
REQ-026 Total sweep time start-accept to done = DEPTH + RD_LAT + 1 cycles.
REQ-027 start coincident with done SHALL be ignored (FSM not yet IDLE).

Reset
REQ-028 rst=1 SHALL force IDLE; re_req, addr_out, busy, done, pass, err_count, first_err_addr, pipeline valids all 0.
REQ-029 rst mid-sweep SHALL abort with no done pulse; in-flight read data discarded.

Configuration
REQ-030 Macro SRAM_CHK_CKBD_EN defined: expected data = exp_data at even addresses, ~exp_data at odd addresses (checkerboard).
REQ-031 Macro SRAM_CHK_CKBD_EN undefined: expected data = exp_data at every address.

Structure
REQ-032 Package sram_pkg SHALL hold the FSM state enum and default WIDTH/DEPTH constants.
REQ-033 Sub-module sram_rd_pipe SHALL implement the RD_LAT valid/address delay line.

Verification (WIDTH=4, DEPTH=32, RD_LAT=1, SRAM behavioural model)
REQ-034 SRAM pre-filled 4'b1010 everywhere, start with exp_data=4'b1010 -> re_req high 32 cycles, addr 0..31, done after 34 cycles, pass=1, err_count=0.
REQ-035 Same fill, word 7 corrupted to 4'b0000 -> err_count=1, first_err_addr=7, pass=0.
REQ-036 Words 3 and 20 corrupted -> err_count=2, first_err_addr=3.
REQ-037 rst asserted at addr_out=10 -> all outputs 0 next cycle, no done; fresh start completes normally.
REQ-038 start pulsed again during busy -> ignored, single done pulse, addr sequence unbroken.
REQ-039 SRAM_CHK_CKBD_EN defined, SRAM filled 1010/0101 alternating, exp_data=4'b1010 -> pass=1; uniform 1010 fill -> err_count=16, first_err_addr=1.
